ip_fixer_process: RTL and testbench

//  Downstream partner of the IP-fixer preprocess stage; both sit on the same datapath input.

---
 rtl/ip_fixer_process.sv | 147 ++++++++++++++
 tb/tb_ip_fixer_process.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_fixer_process.sv
// ip_fixer_process: buffers packets in an input FIFO, waits for the preprocess result,
// then overwrites the IPv4 total-length (W2[63:48]) and checksum (W3[63:48]) fields.
// Optional: define IP_FIXER_PROC_STATS_EN to add the num_ip_fixed counter port.
module ip_fixer_process #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [15:0]           new_ip_length,
  input  logic [15:0]           new_ip_checksum,
  input  logic                  pkt_is_ip,
  input  logic                  new_data_avail,
  output logic                  new_data_rd_en
`ifdef IP_FIXER_PROC_STATS_EN
  ,
  output logic [31:0]           num_ip_fixed
`endif
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;
  localparam logic [CntW-1:0] FullCnt       = CntW'(Depth);
  localparam logic [CntW-1:0] NearlyFullCnt = CntW'(Depth - 2);

  // State names the data word that the next pop delivers; W0 is popped while in StHdr.
  typedef enum logic [4:0] {
    StHdr = 5'b00001,
    StW1  = 5'b00010,
    StW2  = 5'b00100,
    StW3  = 5'b01000,
    StEop = 5'b10000
  } state_e;

  state_e state_q;

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_q [Depth];
  logic [FIFO_DEPTH_BITS-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                  count_q, count_d;

  logic                  fifo_wr, fifo_empty, stall, pop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data, fixed_data;

  assign fifo_empty = (count_q == '0);
  // A write into a full FIFO is an upstream protocol error; the word is dropped.
  assign fifo_wr    = in_wr && (count_q != FullCnt);
  // The length word may not leave until the preprocess result is available.
  assign stall      = (state_q == StW2) && !new_data_avail;
  assign pop        = !fifo_empty && out_rdy && !stall;
  assign {head_ctrl, head_data} = mem_q[rd_ptr_q];
  // Result entry is consumed with the checksum word, keeping one pop per packet.
  assign new_data_rd_en = pop && (state_q == StW3);

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    if (fifo_wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_wr && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Field substitution for IP packets
  always_comb begin
    fixed_data = head_data;
    if (pkt_is_ip) begin
      if (state_q == StW2) begin
        fixed_data[DATA_WIDTH-1 -: 16] = new_ip_length;
      end else if (state_q == StW3) begin
        fixed_data[DATA_WIDTH-1 -: 16] = new_ip_checksum;
      end
    end
  end

  // FIFO storage (no reset needed: contents are qualified by count)
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {in_ctrl, in_data};
    end
  end

  // FIFO pointers, occupancy and registered ready (threshold leaves 2 free entries)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_rdy   <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      in_rdy  <= (count_d < NearlyFullCnt);
    end
  end

  // Packet-position FSM with registered output word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StHdr;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data <= fixed_data;
        out_ctrl <= head_ctrl;
        unique case (state_q)
          StHdr:   if (head_ctrl == '0) state_q <= StW1;
          StW1:    state_q <= StW2;
          StW2:    state_q <= StW3;
          StW3:    state_q <= StEop;
          StEop:   if (head_ctrl != '0) state_q <= StHdr;
          default: state_q <= StHdr;
        endcase
      end
    end
  end

`ifdef IP_FIXER_PROC_STATS_EN
  logic [31:0] num_ip_fixed_q;

  // Count IP packets whose fields were rewritten; wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_ip_fixed_q <= '0;
    end else if (new_data_rd_en && pkt_is_ip) begin
      num_ip_fixed_q <= num_ip_fixed_q + 32'd1;
    end
  end

  assign num_ip_fixed = num_ip_fixed_q;
`endif

endmodule

// File: tb/tb_ip_fixer_process.sv
// Scoreboard bench for ip_fixer_process: driver pushes expected words, monitor pops and compares.
module tb_ip_fixer_process;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [15:0] new_ip_length, new_ip_checksum;
  logic        pkt_is_ip, new_data_avail, new_data_rd_en;
`ifdef IP_FIXER_PROC_STATS_EN
  logic [31:0] num_ip_fixed;
`endif

  always #5 clk = ~clk;

  ip_fixer_process dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_data         (in_data),
    .in_ctrl         (in_ctrl),
    .in_wr           (in_wr),
    .in_rdy          (in_rdy),
    .out_data        (out_data),
    .out_ctrl        (out_ctrl),
    .out_wr          (out_wr),
    .out_rdy         (out_rdy),
    .new_ip_length   (new_ip_length),
    .new_ip_checksum (new_ip_checksum),
    .pkt_is_ip       (pkt_is_ip),
    .new_data_avail  (new_data_avail),
    .new_data_rd_en  (new_data_rd_en)
`ifdef IP_FIXER_PROC_STATS_EN
    ,
    .num_ip_fixed    (num_ip_fixed)
`endif
  );

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int rd_cnt = 0;
  int exp_rd = 0;
  int rdy_mode = 0;
  logic saw_full = 1'b0;
  logic [71:0] sb[$];

  // Preprocess result FIFO model
  logic [15:0] pp_len [64];
  logic [15:0] pp_csum[64];
  logic        pp_ip  [64];
  logic [6:0]  pp_wr = '0;
  logic [6:0]  pp_rd = '0;
  logic        avail_en = 1'b1;

  assign new_data_avail  = avail_en && (pp_wr != pp_rd);
  assign new_ip_length   = pp_len[pp_rd[5:0]];
  assign new_ip_checksum = pp_csum[pp_rd[5:0]];
  assign pkt_is_ip       = pp_ip[pp_rd[5:0]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pp_rd <= pp_wr;
    else if (new_data_rd_en) pp_rd <= pp_rd + 7'd1;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = ~out_rdy;
      3: out_rdy = 1'b0;
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare every presented output word against the scoreboard head
  always @(negedge clk) begin
    logic [71:0] e;
    if (reset_n) begin
      if (!in_rdy && rdy_mode == 0) saw_full = 1'b1;
      if (new_data_rd_en) begin
        checks++;
        rd_cnt++;
        if (!new_data_avail) begin
          errors++;
          $display("FAIL rd_en_without_avail: got rd_en=1 with avail=0");
        end
      end
      if (out_wr) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h_%h expected none", out_ctrl, out_data);
        end else begin
          e = sb.pop_front();
          if ({out_ctrl, out_data} !== e) begin
            errors++;
            $display("FAIL out_word: got %h_%h expected %h_%h", out_ctrl, out_data,
                     e[71:64], e[63:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Build one packet, record its preprocess result and expected output, then drive it
  task automatic send_pkt(input int nhdr, input int n0, input int eop_bytes, input logic is_ip,
                          input logic zero_fields, input int gap);
    logic [71:0] w[$];
    logic [71:0] e;
    logic [63:0] d;
    logic [7:0]  c;
    logic [15:0] len, csum;
    int k, guard;
    for (int i = 0; i < nhdr; i++) begin
      c = 8'($urandom_range(1, 255));
      w.push_back({c, $urandom, $urandom});
    end
    for (int i = 0; i < n0; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) d[31:16] = is_ip ? 16'h0800 : ($urandom_range(0, 1) ? 16'h0806 : 16'h86DD);
      if (zero_fields && (i == 2 || i == 3)) d[63:48] = 16'h0000;
      w.push_back({8'h00, d});
    end
    c = 8'h80 >> (eop_bytes - 1);
    w.push_back({c, $urandom, $urandom});
    len  = 16'(n0 * 8 + eop_bytes - 14);
    csum = 16'($urandom);
    pp_len[pp_wr[5:0]]  = len;
    pp_csum[pp_wr[5:0]] = csum;
    pp_ip[pp_wr[5:0]]   = is_ip;
    pp_wr = pp_wr + 7'd1;
    for (int i = 0; i < w.size(); i++) begin
      e = w[i];
      if (is_ip && i == nhdr + 2) e[63:48] = len;
      if (is_ip && i == nhdr + 3) e[63:48] = csum;
      sb.push_back(e);
    end
    exp_rd++;
    k = 0;
    guard = 0;
    while (k < w.size()) begin
      @(posedge clk);
      #1;
      if (in_rdy && $urandom_range(0, 99) >= gap) begin
        in_wr = 1'b1;
        {in_ctrl, in_data} = w[k];
        k++;
      end else begin
        in_wr = 1'b0;
      end
      guard++;
      if (guard > 5000) begin
        chk("send_timeout", 64'(k), 64'(w.size()));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || pp_wr != pp_rd) && g < 4000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("rd_en_count", 64'(rd_cnt), 64'(exp_rd));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_wr   = 1'b0;
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_rd_en", 64'(new_data_rd_en), 64'd0);
    sb.delete();
    exp_rd = rd_cnt;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_rdy_after_reset", 64'(in_rdy), 64'd1);
  endtask

  initial begin
    int base, rd0, g;
    #2;
    do_reset();

    // Single IP packet, 74 bytes, zeroed length/checksum fields
    send_pkt(1, 9, 2, 1'b1, 1'b1, 0);
    drain();

    // Non-IP packet forwarded unchanged
    send_pkt(2, 8, 8, 1'b0, 1'b0, 0);
    drain();

    // Preprocess result withheld: W2 must stall and the FIFO must fill
    avail_en = 1'b0;
    saw_full = 1'b0;
    base = n_out;
    rd0  = rd_cnt;
    fork
      send_pkt(1, 40, 4, 1'b1, 1'b0, 0);
      begin
        repeat (80) @(posedge clk);
        #2;
        chk("stall_words_out", 64'(n_out - base), 64'd3);
        chk("stall_no_rd_en", 64'(rd_cnt - rd0), 64'd0);
        chk("stall_in_rdy_dropped", 64'(saw_full), 64'd1);
        avail_en = 1'b1;
      end
    join
    drain();

    // Back-to-back packets with out_rdy toggling every cycle
    rdy_mode = 1;
    send_pkt(0, 8, 3, 1'b1, 1'b0, 0);
    send_pkt(1, 9, 5, 1'b0, 1'b0, 0);
    send_pkt(1, 7, 8, 1'b1, 1'b0, 0);
    drain();

    // Randomized traffic with random backpressure and input gaps
    rdy_mode = 2;
    for (int p = 0; p < 8; p++) begin
      send_pkt($urandom_range(0, 2), $urandom_range(7, 14), $urandom_range(1, 8),
               1'($urandom_range(0, 1)), 1'b0, 30);
    end
    drain();

    // Reset in the middle of packet 1, then a clean packet 2
    rdy_mode = 3;
    base = n_out;
    send_pkt(1, 10, 6, 1'b1, 1'b0, 0);
    rdy_mode = 0;
    g = 0;
    while (n_out < base + 4 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("reach_w3", 64'(n_out - base), 64'd4);
    do_reset();
    send_pkt(1, 9, 2, 1'b1, 1'b0, 0);
    drain();

`ifdef IP_FIXER_PROC_STATS_EN
    do_reset();
    chk("stats_reset", 64'(num_ip_fixed), 64'd0);
    for (int p = 0; p < 7; p++) send_pkt(1, 8, 4, (p < 5), 1'b0, 0);
    drain();
    chk("stats_count", 64'(num_ip_fixed), 64'd5);
    @(negedge clk);
    dut.num_ip_fixed_q = 32'hFFFF_FFFF;
    send_pkt(1, 8, 4, 1'b1, 1'b0, 0);
    drain();
    chk("stats_wrap", 64'(num_ip_fixed), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
